// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer. It walks the register list lowest index first,
// making one memory access per set bit, then writes the final address back to Rn.
module ldm_stm_sequencer (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        L,
  input  logic        P,
  input  logic        U,
  input  logic        W,
  input  logic [3:0]  Rn,
  input  logic [31:0] BaseAddr,
  input  logic [15:0] RegList,
  input  logic        MemReady,
  input  logic [31:0] MemRD,
  input  logic [31:0] RegRD,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] MemAddr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemWD,
  output logic [3:0]  RegA,
  output logic [3:0]  RegA3,
  output logic [31:0] RegWD3,
  output logic        RegWrite,
  output logic        PCLoad,
  output logic [31:0] PCValue
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_XFER, S_WB, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        l_q, l_d, p_q, p_d, u_q, u_d, w_q, w_d;
  logic [3:0]  rn_q, rn_d;
  logic [31:0] base_q, base_d;
  logic [15:0] list_q, list_d;
  logic [15:0] remain_q, remain_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] final_q, final_d;

  logic [4:0]  count;
  logic [31:0] span;
  logic [3:0]  cur;
  logic [15:0] remain_next;

  // The original list is kept intact so WB can tell whether Rn was loaded.
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + {4'd0, list_q[i]};
    span = {25'd0, count, 2'b00};
    cur = '0;
    for (int i = 15; i >= 0; i--) if (remain_q[i]) cur = 4'(i);
    remain_next = remain_q & (remain_q - 16'd1);
  end

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    p_d      = p_q;
    u_d      = u_q;
    w_d      = w_q;
    rn_d     = rn_q;
    base_d   = base_q;
    list_d   = list_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    final_d  = final_q;
    case (state_q)
      S_IDLE: if (Start) begin
        l_d      = L;
        p_d      = P;
        u_d      = U;
        w_d      = W;
        rn_d     = Rn;
        base_d   = BaseAddr;
        list_d   = RegList;
        remain_d = RegList;
        state_d  = S_CALC;
      end
      S_CALC: begin
        case ({p_q, u_q})
          2'b01:   addr_d = base_q;
          2'b11:   addr_d = base_q + 32'd4;
          2'b00:   addr_d = base_q - span + 32'd4;
          default: addr_d = base_q - span;
        endcase
        final_d = u_q ? base_q + span : base_q - span;
        state_d = (count == 5'd0) ? S_DONE : S_XFER;
      end
      S_XFER: if (MemReady) begin
        remain_d = remain_next;
        addr_d   = addr_q + 32'd4;
        if (remain_next == 16'd0) state_d = w_q ? S_WB : S_DONE;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state_q != S_IDLE);
    Done     = (state_q == S_DONE);
    MemAddr  = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemWD    = '0;
    RegA     = '0;
    RegA3    = '0;
    RegWD3   = '0;
    RegWrite = 1'b0;
    PCLoad   = 1'b0;
    PCValue  = '0;
    case (state_q)
      S_XFER: begin
        MemAddr  = addr_q;
        MemRead  = l_q;
        MemWrite = !l_q;
        if (!l_q) begin
          RegA  = cur;
          MemWD = RegRD;
        end else if (MemReady) begin
          if (cur != 4'd15) begin
            RegWrite = 1'b1;
            RegA3    = cur;
            RegWD3   = MemRD;
          end else begin
            PCLoad  = 1'b1;
            PCValue = MemRD;
          end
        end
      end
      // A loaded Rn takes priority over the base writeback.
      S_WB: if (!(l_q && list_q[rn_q])) begin
        RegWrite = 1'b1;
        RegA3    = rn_q;
        RegWD3   = final_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      l_q      <= 1'b0;
      p_q      <= 1'b0;
      u_q      <= 1'b0;
      w_q      <= 1'b0;
      rn_q     <= '0;
      base_q   <= '0;
      list_q   <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      final_q  <= '0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      p_q      <= p_d;
      u_q      <= u_d;
      w_q      <= w_d;
      rn_q     <= rn_d;
      base_q   <= base_d;
      list_q   <= list_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      final_q  <= final_d;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: models the register file and data memory,
// and scores every store, load, PC load, writeback and Done pulse against a queue.
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        Reset, Start, L, P, U, W, MemReady;
  logic [3:0]  Rn;
  logic [31:0] BaseAddr, MemRD, RegRD;
  logic [15:0] RegList;
  logic        Busy, Done, MemRead, MemWrite, RegWrite, PCLoad;
  logic [31:0] MemAddr, MemWD, RegWD3, PCValue;
  logic [3:0]  RegA, RegA3;

  logic [31:0] mem [1024];
  logic [31:0] regs [16];

  localparam int K_NONE = 0, K_ST = 1, K_LD = 2, K_PC = 3, K_WB = 4, K_DONE = 5;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  idx;
    logic [31:0] data;
    int          cyc;
  } sbEntry_t;

  sbEntry_t expQ[$];
  int cyc;
  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  ldm_stm_sequencer dut (
    .clk(clk), .Reset(Reset), .Start(Start), .L(L), .P(P), .U(U), .W(W),
    .Rn(Rn), .BaseAddr(BaseAddr), .RegList(RegList), .MemReady(MemReady),
    .MemRD(MemRD), .RegRD(RegRD), .Busy(Busy), .Done(Done), .MemAddr(MemAddr),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemWD(MemWD), .RegA(RegA),
    .RegA3(RegA3), .RegWD3(RegWD3), .RegWrite(RegWrite), .PCLoad(PCLoad),
    .PCValue(PCValue)
  );

  assign MemRD = mem[MemAddr[11:2]];
  assign RegRD = regs[RegA];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] allOutputs();
    return {18'd0, Busy, Done, MemAddr, MemRead, MemWrite, MemWD, RegA, RegA3,
            RegWD3, RegWrite, PCLoad, PCValue};
  endfunction

  task automatic expectEvent(input int kind, input logic [31:0] addr, input logic [3:0] idx,
                             input logic [31:0] data, input int c);
    sbEntry_t e;
    e.kind = kind;
    e.addr = addr;
    e.idx  = idx;
    e.data = data;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  task automatic scoreEvent(input int kind, input logic [31:0] addr, input logic [3:0] idx,
                            input logic [31:0] data);
    sbEntry_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_event", 160'(kind), 160'(K_NONE));
      return;
    end
    e = expQ.pop_front();
    checkOutput("event_kind", 160'(kind), 160'(e.kind));
    checkOutput("event_addr", 160'(addr), 160'(e.addr));
    checkOutput("event_idx", 160'(idx), 160'(e.idx));
    checkOutput("event_data", 160'(data), 160'(e.data));
    checkOutput("event_cycle", 160'(cyc), 160'(e.cyc));
  endtask

  // One clock cycle: inputs change mid-cycle, outputs are sampled 1ns later,
  // then the memory and register-file models commit what the DUT wrote.
  task automatic runCycle(input logic ready, input logic rst, input logic start);
    @(negedge clk);
    Reset    = rst;
    MemReady = ready;
    Start    = start;
    if (start) cyc = 0;
    else cyc++;
    #1;
    if (MemWrite && MemReady) scoreEvent(K_ST, MemAddr, RegA, MemWD);
    if (MemRead && MemReady && RegWrite) scoreEvent(K_LD, MemAddr, RegA3, RegWD3);
    if (MemRead && MemReady && PCLoad) scoreEvent(K_PC, MemAddr, 4'd0, PCValue);
    if (RegWrite && !MemRead) scoreEvent(K_WB, 32'd0, RegA3, RegWD3);
    if (Done) begin
      scoreEvent(K_DONE, 32'd0, 4'd0, 32'd0);
      checkOutput("busy_at_done", 160'(Busy), 160'(1));
    end
    if (MemWrite && MemReady) mem[MemAddr[11:2]] = MemWD;
    if (RegWrite) regs[RegA3] = RegWD3;
  endtask

  task automatic applyStimulus(input logic l, input logic p, input logic u, input logic w,
                               input logic [3:0] rn, input logic [31:0] base,
                               input logic [15:0] list);
    L        = l;
    P        = p;
    U        = u;
    W        = w;
    Rn       = rn;
    BaseAddr = base;
    RegList  = list;
    runCycle(1'b1, 1'b0, 1'b1);
  endtask

  task automatic finishTest(input string name);
    checkOutput({name, "_queue_drained"}, 160'(expQ.size()), 160'(0));
    checkOutput({name, "_idle"}, 160'(Busy), 160'(0));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; L = 1'b0; P = 1'b0; U = 1'b0; W = 1'b0;
    Rn = '0; BaseAddr = '0; RegList = '0; MemReady = 1'b1; cyc = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;

    $display("[TB] reset");
    runCycle(1'b1, 1'b1, 1'b0);
    runCycle(1'b1, 1'b1, 1'b0);
    checkOutput("reset_outputs", allOutputs(), 160'(0));
    runCycle(1'b1, 1'b0, 1'b0);

    $display("[TB] STM IA with writeback");
    regs[0] = 32'hA; regs[1] = 32'hB; regs[3] = 32'hD;
    expectEvent(K_ST, 32'h100, 4'd0, 32'hA, 2);
    expectEvent(K_ST, 32'h104, 4'd1, 32'hB, 3);
    expectEvent(K_ST, 32'h108, 4'd3, 32'hD, 4);
    expectEvent(K_WB, 32'h0, 4'd4, 32'h10C, 5);
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 6);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h100, 16'h000B);
    for (int c = 1; c <= 8; c++) runCycle(1'b1, 1'b0, 1'b0);
    finishTest("stm_ia");
    checkOutput("stm_ia_r4", 160'(regs[4]), 160'(32'h10C));
    checkOutput("stm_ia_mem108", 160'(mem[32'h108 >> 2]), 160'(32'hD));

    $display("[TB] LDM DB with writeback");
    mem[32'h1F8 >> 2] = 32'h1111_0004;
    mem[32'h1FC >> 2] = 32'h2222_0005;
    expectEvent(K_LD, 32'h1F8, 4'd4, 32'h1111_0004, 2);
    expectEvent(K_LD, 32'h1FC, 4'd5, 32'h2222_0005, 3);
    expectEvent(K_WB, 32'h0, 4'd13, 32'h1F8, 4);
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h0030);
    for (int c = 1; c <= 7; c++) runCycle(1'b1, 1'b0, 1'b0);
    finishTest("ldm_db");
    checkOutput("ldm_db_r13", 160'(regs[13]), 160'(32'h1F8));

    $display("[TB] LDM IB including r15");
    mem[32'h44 >> 2] = 32'h11;
    mem[32'h48 >> 2] = 32'h300;
    expectEvent(K_LD, 32'h44, 4'd0, 32'h11, 2);
    expectEvent(K_PC, 32'h48, 4'd0, 32'h300, 3);
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 32'h40, 16'h8001);
    for (int c = 1; c <= 6; c++) runCycle(1'b1, 1'b0, 1'b0);
    finishTest("ldm_pc");
    checkOutput("ldm_pc_r15_untouched", 160'(regs[15]), 160'(0));

    $display("[TB] LDM IA with three stall cycles on the second transfer");
    mem[32'h300 >> 2] = 32'h30;
    mem[32'h304 >> 2] = 32'h31;
    mem[32'h308 >> 2] = 32'h32;
    expectEvent(K_LD, 32'h300, 4'd0, 32'h30, 2);
    expectEvent(K_LD, 32'h304, 4'd1, 32'h31, 6);
    expectEvent(K_LD, 32'h308, 4'd2, 32'h32, 7);
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 8);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 32'h300, 16'h0007);
    for (int c = 1; c <= 10; c++) begin
      runCycle(!(c >= 3 && c <= 5), 1'b0, 1'b0);
      if (c >= 3 && c <= 5) begin
        checkOutput("stall_addr", 160'(MemAddr), 160'(32'h304));
        checkOutput("stall_read", 160'({MemRead, MemWrite}), 160'(2'b10));
        checkOutput("stall_no_write", 160'({RegWrite, PCLoad}), 160'(0));
      end
    end
    finishTest("stall");

    $display("[TB] empty register list");
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h700, 16'h0000);
    for (int c = 1; c <= 4; c++) begin
      runCycle(1'b1, 1'b0, 1'b0);
      if (c <= 2) checkOutput("empty_no_strobes", 160'({MemRead, MemWrite, RegWrite, PCLoad}), 160'(0));
    end
    finishTest("empty");

    $display("[TB] LDM with writeback and Rn in the list");
    mem[32'h100 >> 2] = 32'h1001;
    mem[32'h104 >> 2] = 32'h1002;
    expectEvent(K_LD, 32'h100, 4'd1, 32'h1001, 2);
    expectEvent(K_LD, 32'h104, 4'd2, 32'h1002, 3);
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h100, 16'h0006);
    for (int c = 1; c <= 7; c++) runCycle(1'b1, 1'b0, 1'b0);
    finishTest("ldm_rn_in_list");
    checkOutput("ldm_rn_keeps_loaded", 160'(regs[1]), 160'(32'h1001));

    $display("[TB] reset during the second of three STM transfers");
    regs[0] = 32'h70; regs[1] = 32'h71; regs[2] = 32'h72;
    expectEvent(K_ST, 32'h500, 4'd0, 32'h70, 2);
    expectEvent(K_ST, 32'h504, 4'd1, 32'h71, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h500, 16'h0007);
    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b1, 1'b0);
    runCycle(1'b1, 1'b1, 1'b0);
    checkOutput("mid_reset_outputs", allOutputs(), 160'(0));
    runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_outputs", allOutputs(), 160'(0));
    finishTest("mid_reset");
    checkOutput("mid_reset_no_third_write", 160'(mem[32'h508 >> 2]), 160'(0));
    checkOutput("mid_reset_no_wb", 160'(regs[9]), 160'(0));

    $display("[TB] new transfer after reset");
    expectEvent(K_ST, 32'h600, 4'd0, 32'h70, 2);
    expectEvent(K_DONE, 32'h0, 4'd0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 32'h600, 16'h0001);
    for (int c = 1; c <= 5; c++) runCycle(1'b1, 1'b0, 1'b0);
    finishTest("restart");
    checkOutput("restart_mem600", 160'(mem[32'h600 >> 2]), 160'(32'h70));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
